// File: rtl/keccak_obi_responder.sv
// OBI responder for the Keccak window: holds DIN/DOUT state, CTRL/STATUS, and sequences one permutation per start.
// Zero-wait-state grant, registered single-cycle response; no backpressure toward the requester.
module keccak_obi_responder #(
  parameter int OFFSET_W = 10,
  parameter int NWORDS   = 50
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [31:0]            addr_i,
  input  logic                   we_i,
  input  logic [3:0]             be_i,
  input  logic [31:0]            wdata_i,
  output logic                   rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   keccak_start_o,
  input  logic                   keccak_ready_i,
  output logic [32*NWORDS-1:0]   keccak_din_o,
  input  logic [32*NWORDS-1:0]   keccak_dout_i
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        start_d;
  logic        done_q;
  logic [31:0] din  [NWORDS];
  logic [31:0] dout [NWORDS];

  logic [31:0] off;
  logic [23:0] region;
  logic [5:0]  widx;
  logic        word_ok;
  logic        din_hit, dout_hit, ctrl_hit, status_hit;
  logic        rd, wr, start_cmd, busy, capture;
  logic [31:0] rdata_d;
  logic        unused_addr;

  // Offsets above the decoded window are zero-extended so region compares stay simple.
  assign off        = 32'(addr_i[OFFSET_W-1:0]);
  assign region     = off[31:8];
  assign widx       = off[7:2];
  assign word_ok    = (widx < 6'(NWORDS));
  assign din_hit    = (region == 24'd0) && word_ok;
  assign dout_hit   = (region == 24'd1) && word_ok;
  assign ctrl_hit   = (region == 24'd2) && (widx == 6'd0);
  assign status_hit = (region == 24'd2) && (widx == 6'd1);
  assign unused_addr = ^{addr_i[31:OFFSET_W], off[1:0]};

  assign gnt_o     = req_i;
  assign rd        = req_i & ~we_i;
  assign wr        = req_i & we_i;
  assign start_cmd = wr & ctrl_hit & be_i[0] & wdata_i[0];
  assign busy      = (state_q == BUSY);
  assign capture   = busy & keccak_ready_i;

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_cmd) begin
          state_d = BUSY;
          start_d = 1'b1;
        end
      end
      BUSY: begin
        if (keccak_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      keccak_start_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      keccak_start_o <= start_d;
    end
  end

  // A completing permutation outranks a clear-on-read in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
    end else if (capture) begin
      done_q <= 1'b1;
    end else if (start_d) begin
      done_q <= 1'b0;
    end else if (rd && status_hit) begin
      done_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NWORDS; k++) begin
        din[k] <= '0;
      end
    end else if (wr && din_hit && !busy) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          din[widx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NWORDS; k++) begin
        dout[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < NWORDS; k++) begin
        dout[k] <= keccak_dout_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      if (din_hit) begin
        rdata_d = din[widx];
      end else if (dout_hit) begin
        rdata_d = dout[widx];
      end else if (status_hit) begin
        rdata_d = {30'd0, done_q, busy};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= req_i;
      rdata_o  <= rdata_d;
    end
  end

  for (genvar k = 0; k < NWORDS; k++) begin : g_din
    assign keccak_din_o[32*k +: 32] = din[k];
  end

endmodule

// File: tb/tb_keccak_obi_responder.sv
// Randomized scoreboard bench for keccak_obi_responder against a byte-address-level model of the register window.
module tb_keccak_obi_responder;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_i;
  logic          gnt_o;
  logic [31:0]   addr_i;
  logic          we_i;
  logic [3:0]    be_i;
  logic [31:0]   wdata_i;
  logic          rvalid_o;
  logic [31:0]   rdata_o;
  logic          keccak_start_o;
  logic          keccak_ready_i;
  logic [1599:0] keccak_din_o;
  logic [1599:0] keccak_dout_i;

  always #5 clk_i = ~clk_i;

  keccak_obi_responder dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .gnt_o          (gnt_o),
    .addr_i         (addr_i),
    .we_i           (we_i),
    .be_i           (be_i),
    .wdata_i        (wdata_i),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .keccak_start_o (keccak_start_o),
    .keccak_ready_i (keccak_ready_i),
    .keccak_din_o   (keccak_din_o),
    .keccak_dout_i  (keccak_dout_i)
  );

  logic [31:0]   m_din  [50];
  logic [31:0]   m_dout [50];
  bit            m_busy;
  bit            m_done;
  logic [1599:0] kdout;
  logic [31:0]   exp_q [$];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_din();
    int bad;
    bad = -1;
    for (int k = 0; k < 50; k++) begin
      if (bad < 0 && keccak_din_o[32*k +: 32] !== m_din[k]) bad = k;
    end
    n_cmp++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL din_port word %0d: got %h, expected %h at %0t",
               bad, keccak_din_o[32*bad +: 32], m_din[bad], $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int o;
    o = int'(a[9:0]);
    if (o < 200) return m_din[o/4];
    if (o >= 256 && o < 456) return m_dout[(o-256)/4];
    if (o/4 == 129) return {30'd0, m_done, m_busy};
    return 32'd0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 50; k++) begin
      m_din[k]  = '0;
      m_dout[k] = '0;
    end
    m_busy = 0;
    m_done = 0;
    exp_q.delete();
  endtask

  // One bus cycle: drive, update the model, then check cycle-level outputs after the edge.
  task automatic cycle(input bit rq, input bit we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input bit rdy);
    bit was_busy, start_now;
    int o;
    req_i = rq; we_i = we; addr_i = a; be_i = be; wdata_i = wd;
    keccak_ready_i = rdy; keccak_dout_i = kdout;
    was_busy = m_busy;
    start_now = 0;
    o = int'(a[9:0]);
    if (rq) begin
      exp_q.push_back(we ? 32'd0 : model_read(a));
      if (!we && o/4 == 129) m_done = 0;
      if (we && !was_busy) begin
        if (o < 200) begin
          for (int b = 0; b < 4; b++) if (be[b]) m_din[o/4][8*b +: 8] = wd[8*b +: 8];
        end
        if (o/4 == 128 && be[0] && wd[0]) begin
          start_now = 1;
          m_busy = 1;
          m_done = 0;
        end
      end
    end
    if (rdy && was_busy) begin
      for (int k = 0; k < 50; k++) m_dout[k] = kdout[32*k +: 32];
      m_done = 1;
      m_busy = 0;
    end
    #1;
    check("gnt", {31'd0, gnt_o}, {31'd0, rq});
    @(posedge clk_i);
    #1;
    check("rvalid", {31'd0, rvalid_o}, {31'd0, rq});
    check("start_pulse", {31'd0, keccak_start_o}, {31'd0, start_now});
    check_din();
  endtask

  task automatic rd_bus(input logic [31:0] a);
    cycle(1, 0, a, 4'hF, 32'd0, 0);
  endtask

  task automatic wr_bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cycle(1, 1, a, be, d, 0);
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 0, 32'd0, 4'h0, 32'd0, rdy);
  endtask

  task automatic do_reset();
    req_i = 0; we_i = 0; keccak_ready_i = 0;
    rst_i = 1;
    #1;
    model_clear();
    check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_start", {31'd0, keccak_start_o}, 32'd0);
    check("rst_gnt", {31'd0, gnt_o}, 32'd0);
    check_din();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 0;
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && rvalid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rdata: unexpected response %h at %0t", rdata_o, $time);
      end else begin
        check("rdata", rdata_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    int sel, off;
    bit rq, we, rdy;
    logic [31:0] a;
    rst_i = 1; req_i = 0; addr_i = 0; we_i = 0; be_i = 0; wdata_i = 0;
    keccak_ready_i = 0;
    kdout = '0;
    keccak_dout_i = '0;
    @(posedge clk_i);
    #1;
    do_reset();

    rd_bus(32'h204);
    rd_bus(32'h00C);
    wr_bus(32'h00C, 32'hDEADBEEF, 4'b0101);
    rd_bus(32'h00C);
    check("din_w3_port", keccak_din_o[127:96], 32'h00AD00EF);

    for (int k = 0; k < 50; k++) kdout[32*k +: 32] = $urandom;
    kdout[31:0] = 32'h12345678;
    wr_bus(32'h200, 32'h1, 4'h1);
    rd_bus(32'h204);
    wr_bus(32'h000, 32'hFFFFFFFF, 4'hF);
    wr_bus(32'h200, 32'h1, 4'hF);
    rd_bus(32'h000);
    idle(0);
    idle(1);
    rd_bus(32'h204);
    rd_bus(32'h100);
    rd_bus(32'h204);

    kdout[63:32] = 32'hCAFEF00D;
    wr_bus(32'h200, 32'h1, 4'h1);
    cycle(1, 0, 32'h204, 4'hF, 32'd0, 1);
    rd_bus(32'h204);
    rd_bus(32'h3F0);
    wr_bus(32'h104, 32'h55555555, 4'hF);
    rd_bus(32'h104);

    wr_bus(32'h008, 32'hA5A5A5A5, 4'hF);
    wr_bus(32'h200, 32'h1, 4'h1);
    idle(0);
    do_reset();
    rd_bus(32'h204);
    rd_bus(32'h008);
    idle(1);
    rd_bus(32'h204);

    for (int i = 0; i < 3000; i++) begin
      rq = ($urandom_range(0, 9) < 7);
      we = $urandom_range(0, 1) == 1;
      sel = $urandom_range(0, 5);
      case (sel)
        0: off = 4 * $urandom_range(0, 49);
        1: off = 256 + 4 * $urandom_range(0, 49);
        2: off = 32'h200;
        3: off = 32'h204;
        4: off = $urandom_range(0, 1023);
        default: off = 200 + $urandom_range(0, 55);
      endcase
      a = ($urandom & 32'hFFFF_FC00) | 32'(off) | 32'($urandom_range(0, 3));
      rdy = m_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 50; k++) kdout[32*k +: 32] = $urandom;
      end
      cycle(rq, we, a, 4'($urandom_range(0, 15)), $urandom, rdy);
    end

    idle(0);
    idle(0);
    check("pending_responses", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
